// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus: requester FSM encoding,
// default widths and the arbiter's grant-state constants.
package bus_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int LW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } bm_state_e;

  // Arbiter grant state: which master currently owns the bus.
  localparam logic [1:0] ARB_NONE = 2'd0;
  localparam logic [1:0] ARB_M0   = 2'd1;
  localparam logic [1:0] ARB_M1   = 2'd2;

endpackage

// File: rtl/bus_master.sv
// Requester side of the shared bus: takes a burst command, requests the bus,
// runs 1..2^LW beats once granted, returns read data, then releases the bus.
module bus_master
  import bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdat_valid,
  input  logic [DW-1:0] wdat,
  output logic          wdat_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          M_req,
  input  logic          M_grt,
  output logic [AW-1:0] M_addr,
  output logic          M_wr,
  output logic [DW-1:0] M_dout,
  input  logic [DW-1:0] M_din
);

  bm_state_e     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic          rd_vld_q, rd_vld_d;
  logic          adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    adv        = 1'b0;
    cmd_ready  = 1'b0;
    M_req      = 1'b0;
    M_wr       = 1'b0;
    M_addr     = '0;
    M_dout     = '0;
    wdat_ready = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          we_d    = cmd_we;
          base_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        M_req = 1'b1;
        if (M_grt) state_d = XFER;
      end
      XFER: begin
        M_req = 1'b1;
        // Losing the grant mid-burst: stay off the bus, keep the beat, re-request.
        if (!M_grt) begin
          state_d = REQ;
        end else begin
          M_addr = base_q + AW'(beat_q);
          if (we_q) begin
            M_wr       = wdat_valid;
            M_dout     = wdat;
            wdat_ready = wdat_valid;
            adv        = wdat_valid;
          end else begin
            adv = 1'b1;
          end
          if (adv) begin
            if (beat_q == len_q) state_d = DRAIN;
            else                 beat_d  = beat_q + LW'(1);
          end
        end
      end
      DRAIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus read data arrives one cycle after its address.
  assign rd_vld_d = adv & ~we_q;
  assign rd_valid = rd_vld_q;
  assign rd_data  = rd_vld_q ? M_din : '0;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: single-master bursts with a bench-driven
// grant, then two instances sharing a small grant-register arbiter.
module tb_bus_master;
  import bus_pkg::*;

  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid0, cmd_we0, wdat_valid0, grt0_tb, grt0, grt1, arb_en;
  logic [7:0]  cmd_addr0;
  logic [3:0]  cmd_len0;
  logic [31:0] wdat0, M_din0;
  logic        cmd_ready0, wdat_ready0, rd_valid0, done0, M_req0, M_wr0;
  logic [31:0] rd_data0, M_dout0;
  logic [7:0]  M_addr0;

  logic        cmd_valid1, cmd_we1, wdat_valid1;
  logic [7:0]  cmd_addr1;
  logic [3:0]  cmd_len1;
  logic [31:0] wdat1, M_din1;
  logic        cmd_ready1, wdat_ready1, rd_valid1, done1, M_req1, M_wr1;
  logic [31:0] rd_data1, M_dout1;
  logic [7:0]  M_addr1;

  logic [1:0]  arb_q;
  logic [5:0]  ctl0;

  assign grt0 = arb_en ? (arb_q == ARB_M0) : grt0_tb;
  assign grt1 = arb_en && (arb_q == ARB_M1);
  assign ctl0 = {cmd_ready0, M_req0, M_wr0, wdat_ready0, rd_valid0, done0};

  bus_master u0 (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_we(cmd_we0), .cmd_addr(cmd_addr0), .cmd_len(cmd_len0),
    .wdat_valid(wdat_valid0), .wdat(wdat0), .wdat_ready(wdat_ready0),
    .rd_valid(rd_valid0), .rd_data(rd_data0), .done(done0),
    .M_req(M_req0), .M_grt(grt0), .M_addr(M_addr0), .M_wr(M_wr0),
    .M_dout(M_dout0), .M_din(M_din0)
  );

  bus_master u1 (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_we(cmd_we1), .cmd_addr(cmd_addr1), .cmd_len(cmd_len1),
    .wdat_valid(wdat_valid1), .wdat(wdat1), .wdat_ready(wdat_ready1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .done(done1),
    .M_req(M_req1), .M_grt(grt1), .M_addr(M_addr1), .M_wr(M_wr1),
    .M_dout(M_dout1), .M_din(M_din1)
  );

  // Registered arbiter: owner keeps the bus while requesting, M0 wins ties.
  always @(posedge clk) begin
    if (rst) arb_q <= ARB_NONE;
    else begin
      case (arb_q)
        ARB_M0:  if (!M_req0) arb_q <= M_req1 ? ARB_M1 : ARB_NONE;
        ARB_M1:  if (!M_req1) arb_q <= M_req0 ? ARB_M0 : ARB_NONE;
        default: arb_q <= M_req0 ? ARB_M0 : (M_req1 ? ARB_M1 : ARB_NONE);
      endcase
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Settle, then compare the M0 instance against one cycle's expectations.
  task automatic expect0(input string tag, input int c, input logic [5:0] ectl,
                         input logic [7:0] eaddr, input logic [31:0] edout,
                         input logic [31:0] erd);
    #2;
    chk($sformatf("%s c%0d ctl", tag, c), 64'(ctl0), 64'(ectl));
    chk($sformatf("%s c%0d addr", tag, c), 64'(M_addr0), 64'(eaddr));
    chk($sformatf("%s c%0d dout", tag, c), 64'(M_dout0), 64'(edout));
    chk($sformatf("%s c%0d rdata", tag, c), 64'(rd_data0), 64'(erd));
  endtask

  task automatic issue0(input logic we, input logic [7:0] addr, input logic [3:0] len);
    nxt();
    cmd_valid0 = 1'b1; cmd_we0 = we; cmd_addr0 = addr; cmd_len0 = len;
    expect0("cmd", 0, 6'b100000, 8'h00, 32'h0, 32'h0);
  endtask

  logic        e_req, e_rv, e_wr;
  logic [7:0]  e_addr;
  logic [31:0] e_rd, e_dout;
  int          cnt, ovl, d0c, d1c, f1, rv0n, rv1n;

  initial begin
    rst = 1'b1; arb_en = 1'b0; grt0_tb = 1'b0;
    cmd_valid0 = 1'b0; cmd_we0 = 1'b0; cmd_addr0 = 8'h0; cmd_len0 = 4'h0;
    wdat_valid0 = 1'b0; wdat0 = 32'h0; M_din0 = 32'h0;
    cmd_valid1 = 1'b0; cmd_we1 = 1'b0; cmd_addr1 = 8'h0; cmd_len1 = 4'h0;
    wdat_valid1 = 1'b0; wdat1 = 32'h0; M_din1 = 32'h0;

    // Reset values
    nxt(); nxt();
    M_din0 = 32'h1234_5678;
    expect0("reset", 0, 6'b100000, 8'h00, 32'h0, 32'h0);
    nxt(); rst = 1'b0;

    // Read burst 0x10, len 3, grant from cycle 2
    issue0(1'b0, 8'h10, 4'd3);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      cmd_valid0 = 1'b0; grt0_tb = (c >= 2 && c <= 7); M_din0 = 32'hA000_0000 + c;
      e_req  = (c >= 1 && c <= 6);
      e_rv   = (c >= 4 && c <= 7);
      e_addr = (c >= 3 && c <= 6) ? 8'h10 + 8'(c - 3) : 8'h00;
      e_rd   = e_rv ? 32'hA000_0000 + c : 32'h0;
      expect0("rd", c, {c >= 8, e_req, 1'b0, 1'b0, e_rv, c == 7}, e_addr, 32'h0, e_rd);
    end
    grt0_tb = 1'b0;

    // Write burst 0xFE, len 2, wdat_valid low in cycle 4, address wraps
    issue0(1'b1, 8'hFE, 4'd2);
    cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      cmd_valid0 = 1'b0; grt0_tb = (c >= 2 && c <= 7);
      wdat_valid0 = (c == 3 || c == 5 || c == 6); wdat0 = 32'hD000_0000 + c;
      e_req = (c >= 1 && c <= 6);
      e_wr  = (c == 3 || c == 5 || c == 6);
      case (c)
        3:       e_addr = 8'hFE;
        4, 5:    e_addr = 8'hFF;
        default: e_addr = 8'h00;
      endcase
      e_dout = (c >= 3 && c <= 6) ? 32'hD000_0000 + c : 32'h0;
      expect0("wr", c, {c >= 8, e_req, e_wr, e_wr, 1'b0, c == 7}, e_addr, e_dout, 32'h0);
      if (wdat_ready0) cnt++;
    end
    chk("wr beats", 64'(cnt), 64'd3);
    grt0_tb = 1'b0; wdat_valid0 = 1'b0; wdat0 = 32'h0;

    // Contention: grant withheld until cycle 7
    issue0(1'b0, 8'h40, 4'd1);
    for (int c = 1; c <= 11; c++) begin
      nxt();
      cmd_valid0 = 1'b0; grt0_tb = (c >= 7 && c <= 10); M_din0 = 32'hB000_0000 + c;
      e_req  = (c >= 1 && c <= 9);
      e_rv   = (c == 9 || c == 10);
      e_addr = (c == 8) ? 8'h40 : (c == 9) ? 8'h41 : 8'h00;
      e_rd   = e_rv ? 32'hB000_0000 + c : 32'h0;
      expect0("cont", c, {c >= 11, e_req, 1'b0, 1'b0, e_rv, c == 10}, e_addr, 32'h0, e_rd);
    end
    grt0_tb = 1'b0;

    // Grant dropped in cycle 5 (after beat 1 of 4)
    issue0(1'b0, 8'h20, 4'd3);
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      cmd_valid0 = 1'b0; grt0_tb = (c >= 2 && c <= 4) || (c >= 6 && c <= 9);
      M_din0 = 32'h5000_0000 + c;
      e_req = (c >= 1 && c <= 8);
      e_rv  = (c == 4 || c == 5 || c == 8 || c == 9);
      case (c)
        3:       e_addr = 8'h20;
        4:       e_addr = 8'h21;
        7:       e_addr = 8'h22;
        8:       e_addr = 8'h23;
        default: e_addr = 8'h00;
      endcase
      e_rd = e_rv ? 32'h5000_0000 + c : 32'h0;
      expect0("drop", c, {c >= 10, e_req, 1'b0, 1'b0, e_rv, c == 9}, e_addr, 32'h0, e_rd);
      if (rd_valid0) cnt++;
    end
    chk("drop beats", 64'(cnt), 64'd4);
    grt0_tb = 1'b0;

    // Reset asserted during beat 2
    issue0(1'b0, 8'h30, 4'd3);
    for (int c = 1; c <= 7; c++) begin
      nxt();
      cmd_valid0 = 1'b0; grt0_tb = (c >= 2); M_din0 = 32'hC000_0000 + c;
      rst = (c == 5);
      e_req  = (c >= 1 && c <= 5);
      e_rv   = (c == 4 || c == 5);
      e_addr = (c >= 3 && c <= 5) ? 8'h30 + 8'(c - 3) : 8'h00;
      e_rd   = e_rv ? 32'hC000_0000 + c : 32'h0;
      expect0("rst", c, {c >= 6, e_req, 1'b0, 1'b0, e_rv, 1'b0}, e_addr, 32'h0, e_rd);
    end
    grt0_tb = 1'b0;

    // Two masters, simultaneous commands, shared arbiter
    arb_en = 1'b1;
    nxt();
    cmd_valid0 = 1'b1; cmd_we0 = 1'b0; cmd_addr0 = 8'h50; cmd_len0 = 4'd1;
    cmd_valid1 = 1'b1; cmd_we1 = 1'b0; cmd_addr1 = 8'h60; cmd_len1 = 4'd1;
    ovl = 0; d0c = 0; d1c = 0; f1 = 0; rv0n = 0; rv1n = 0;
    for (int c = 1; c <= 12; c++) begin
      nxt();
      cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      M_din0 = 32'hE000_0000 + c; M_din1 = 32'hF000_0000 + c;
      #2;
      if ((rd_valid0 && rd_valid1) || (M_addr0 != 8'h0 && M_addr1 != 8'h0)) ovl++;
      if (done0) d0c = c;
      if (done1) d1c = c;
      if (M_addr1 != 8'h0 && f1 == 0) f1 = c;
      if (rd_valid0) rv0n++;
      if (rd_valid1) begin
        rv1n++;
        chk($sformatf("m1 rdata c%0d", c), 64'(rd_data1), 64'(32'hF000_0000 + c));
      end
    end
    chk("m0 done cycle", 64'(d0c), 64'd5);
    chk("m1 first beat", 64'(f1), 64'd7);
    chk("m1 done cycle", 64'(d1c), 64'd9);
    chk("overlap", 64'(ovl), 64'd0);
    chk("m0 beats", 64'(rv0n), 64'd2);
    chk("m1 beats", 64'(rv1n), 64'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
